pq_heap_ctrl: RTL and testbench

//  Sequencer for the QuickQ binary min-heap held in an external 1-based key RAM (address 0 unused).

---
 rtl/pq_heap_ctrl_if.sv | 51 +++++
 rtl/pq_heap_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pq_heap_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pq_heap_ctrl_if.sv
// Request, result and key-RAM signals of the QuickQ heap sequencer.
// PQ_PEEK_EN adds the min_valid/min_key peek signals.
interface pq_heap_ctrl_if #(
  parameter int KEY_W = 16,
  parameter int DEPTH = 255
);
  localparam int ADDR_W = $clog2(DEPTH + 1);

  logic              enq_valid;
  logic              enq_ready;
  logic [KEY_W-1:0]  enq_key;
  logic              deq_valid;
  logic              deq_ready;
  logic              out_valid;
  logic [KEY_W-1:0]  out_key;
  logic [ADDR_W-1:0] mem_addr_a;
  logic [ADDR_W-1:0] mem_addr_b;
  logic [KEY_W-1:0]  mem_rdata_a;
  logic [KEY_W-1:0]  mem_rdata_b;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [KEY_W-1:0]  mem_wdata;
  logic [ADDR_W-1:0] count;
  logic              empty;
  logic              full;
  logic              busy;
`ifdef PQ_PEEK_EN
  logic              min_valid;
  logic [KEY_W-1:0]  min_key;
`endif

  // requester plus key RAM side
  modport master (
    output enq_valid, enq_key, deq_valid, mem_rdata_a, mem_rdata_b,
    input  enq_ready, deq_ready, out_valid, out_key, mem_addr_a, mem_addr_b,
           mem_we, mem_waddr, mem_wdata, count, empty, full, busy
`ifdef PQ_PEEK_EN
    , input min_valid, min_key
`endif
  );

  // heap sequencer side
  modport slave (
    input  enq_valid, enq_key, deq_valid, mem_rdata_a, mem_rdata_b,
    output enq_ready, deq_ready, out_valid, out_key, mem_addr_a, mem_addr_b,
           mem_we, mem_waddr, mem_wdata, count, empty, full, busy
`ifdef PQ_PEEK_EN
    , output min_valid, min_key
`endif
  );
endinterface

// File: rtl/pq_heap_ctrl.sv
// QuickQ min-heap sequencer: round-robin enq/deq, hole-method sift up/down over a 1-based key RAM.
// Define PQ_PEEK_EN to add the min_valid/min_key peek of the root key.
module pq_heap_ctrl #(
  parameter int KEY_W = 16,
  parameter int DEPTH = 255
) (
  input logic           clk,
  input logic           rst,
  pq_heap_ctrl_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] FULL_CNT = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   ONE      = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {IDLE, UP_RD, UP_CMP, DQ_RD, DQ_LD, DN_RD, DN_CMP} state_t;
  typedef enum logic {G_DEQ = 1'b0, G_ENQ = 1'b1} grant_t;

  state_t            state, nxt;
  grant_t            last_grant;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W:0]   idx;
  logic [KEY_W-1:0]  hold;

  logic              idle, empty, full, enq_ready, deq_ready, enq_acc, deq_acc;
  logic [ADDR_W:0]   cnt_w, l, r, c;
  logic              r_ok, leaf, pick_r, up_move, dn_move;
  logic [KEY_W-1:0]  ckey;

  logic              mem_we, out_valid;
  logic [ADDR_W-1:0] mem_addr_a, mem_addr_b, mem_waddr;
  logic [KEY_W-1:0]  mem_wdata, out_key;

  assign idle  = (state == IDLE);
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  assign enq_ready = idle && !full  && !(bus.deq_valid && !empty && last_grant == G_ENQ);
  assign deq_ready = idle && !empty && !(bus.enq_valid && !full  && last_grant == G_DEQ);
  assign enq_acc   = bus.enq_valid && enq_ready;
  assign deq_acc   = bus.deq_valid && deq_ready;

  // one extra bit keeps 2*idx+1 from wrapping at the bottom level
  assign cnt_w   = {1'b0, count};
  assign l       = idx << 1;
  assign r       = l + ONE;
  assign r_ok    = (r <= cnt_w);
  assign leaf    = (l > cnt_w);
  assign pick_r  = r_ok && (bus.mem_rdata_b < bus.mem_rdata_a);
  assign c       = pick_r ? r : l;
  assign ckey    = pick_r ? bus.mem_rdata_b : bus.mem_rdata_a;
  assign up_move = (hold < bus.mem_rdata_a);
  assign dn_move = (ckey < hold);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (enq_acc) nxt = UP_RD;
               else if (deq_acc) nxt = DQ_RD;
      UP_RD:   nxt = (idx == ONE) ? IDLE : UP_CMP;
      UP_CMP:  nxt = up_move ? UP_RD : IDLE;
      DQ_RD:   nxt = DQ_LD;
      DQ_LD:   nxt = empty ? IDLE : DN_RD;
      DN_RD:   nxt = leaf ? IDLE : DN_CMP;
      DN_CMP:  nxt = dn_move ? DN_RD : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // RAM reads are issued here and consumed the following cycle
  always_comb begin
    mem_addr_a = '0;
    mem_addr_b = '0;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    out_valid  = 1'b0;
    out_key    = '0;
    case (state)
      UP_RD: begin
        if (idx == ONE) begin
          mem_we = 1'b1; mem_waddr = ONE_A; mem_wdata = hold;
        end else begin
          mem_addr_a = ADDR_W'(idx >> 1);
        end
      end
      UP_CMP: begin
        mem_we = 1'b1; mem_waddr = ADDR_W'(idx);
        mem_wdata = up_move ? bus.mem_rdata_a : hold;
      end
      DQ_RD: begin
        mem_addr_a = ONE_A; mem_addr_b = count;
      end
      DQ_LD: begin
        out_valid = 1'b1; out_key = bus.mem_rdata_a;
      end
      DN_RD: begin
        if (leaf) begin
          mem_we = 1'b1; mem_waddr = ADDR_W'(idx); mem_wdata = hold;
        end else begin
          mem_addr_a = ADDR_W'(l); mem_addr_b = ADDR_W'(r);
        end
      end
      DN_CMP: begin
        mem_we = 1'b1; mem_waddr = ADDR_W'(idx);
        mem_wdata = dn_move ? ckey : hold;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      idx        <= '0;
      hold       <= '0;
      last_grant <= G_DEQ;
    end else begin
      case (state)
        IDLE: begin
          if (enq_acc) begin
            hold       <= bus.enq_key;
            idx        <= cnt_w + ONE;
            count      <= count + ONE_A;
            last_grant <= G_ENQ;
          end else if (deq_acc) begin
            last_grant <= G_DEQ;
          end
        end
        UP_CMP: if (up_move) idx <= idx >> 1;
        DQ_RD:  count <= count - ONE_A;
        DQ_LD: begin
          hold <= bus.mem_rdata_b;
          idx  <= ONE;
        end
        DN_CMP: if (dn_move) idx <= c;
        default: ;
      endcase
    end
  end

`ifdef PQ_PEEK_EN
  logic             min_valid;
  logic [KEY_W-1:0] min_key;

  always_ff @(posedge clk) begin
    if (rst) begin
      min_valid <= 1'b0;
      min_key   <= '0;
    end else if (mem_we && mem_waddr == ONE_A) begin
      min_valid <= 1'b1;
      min_key   <= mem_wdata;
    end else if (state == DQ_LD && empty) begin
      min_valid <= 1'b0;
    end
  end

  assign bus.min_valid = min_valid;
  assign bus.min_key   = min_key;
`endif

  assign bus.enq_ready  = enq_ready;
  assign bus.deq_ready  = deq_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_key    = out_key;
  assign bus.mem_addr_a = mem_addr_a;
  assign bus.mem_addr_b = mem_addr_b;
  assign bus.mem_we     = mem_we;
  assign bus.mem_waddr  = mem_waddr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.count      = count;
  assign bus.empty      = empty;
  assign bus.full       = full;
  assign bus.busy       = !idle;
endmodule

// File: tb/tb_pq_heap_ctrl.sv
// Bench for pq_heap_ctrl: directed scenarios plus random enq/deq against a queue-based priority model.
module tb_pq_heap_ctrl;
  localparam int KEY_W  = 8;
  localparam int DEPTH  = 7;
  localparam int ADDR_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pq_heap_ctrl_if #(.KEY_W(KEY_W), .DEPTH(DEPTH)) bus ();
  pq_heap_ctrl #(.KEY_W(KEY_W), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  // key RAM: one-cycle read latency on both ports
  logic [KEY_W-1:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    bus.mem_rdata_a <= ram[bus.mem_addr_a];
    bus.mem_rdata_b <= ram[bus.mem_addr_b];
    if (bus.mem_we) ram[bus.mem_waddr] <= bus.mem_wdata;
  end

  int  q[$];        // reference contents, unordered
  bit  m_last_enq;  // reference last grant
  int  n_cmp, n_err;
  bit  obs_enq, obs_deq;
  bit  ge, gd;
  logic [KEY_W-1:0] dk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int qmin_idx();
    int mi = 0;
    for (int i = 1; i < q.size(); i++) if (q[i] < q[mi]) mi = i;
    return mi;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 64) begin tick(); n++; end
    chk("idle_timeout", bus.busy, 0);
  endtask

  task automatic chk_state();
    int hq[$];
    int mq[$];
    bit ok = 1'b1, ho = 1'b1;
    chk("count", bus.count, q.size());
    chk("empty", bus.empty, q.size() == 0);
    chk("full",  bus.full,  q.size() == DEPTH);
    for (int i = 1; i <= q.size(); i++) hq.push_back(int'(ram[i]));
    for (int i = 2; i <= q.size(); i++) if (ram[i/2] > ram[i]) ho = 1'b0;
    mq = q;
    hq.sort();
    mq.sort();
    for (int i = 0; i < mq.size(); i++) if (hq[i] != mq[i]) ok = 1'b0;
    chk("ram_keys", ok, 1);
    chk("heap_order", ho, 1);
`ifdef PQ_PEEK_EN
    chk("min_valid", bus.min_valid, q.size() > 0);
    if (q.size() > 0) chk("min_key", bus.min_key, q[qmin_idx()]);
`endif
  endtask

  // one request cycle from IDLE, then run the operation to completion
  task automatic xact(input bit ev, input bit dv, input logic [KEY_W-1:0] k,
                      output bit g_e, output bit g_d, output logic [KEY_W-1:0] dkey);
    bit ee, ed, was_empty;
    int mi, mv;
    ee = q.size() < DEPTH && !(dv && q.size() > 0 && m_last_enq);
    ed = q.size() > 0 && !(ev && q.size() < DEPTH && !m_last_enq);
    bus.enq_valid = ev; bus.enq_key = k; bus.deq_valid = dv;
    @(negedge clk);
    obs_enq = bus.enq_ready; obs_deq = bus.deq_ready;
    chk("enq_ready", bus.enq_ready, ee);
    chk("deq_ready", bus.deq_ready, ed);
    g_e = ev && ee; g_d = dv && ed; was_empty = (q.size() == 0); dkey = '0;
    tick();
    bus.enq_valid = 1'b0; bus.deq_valid = 1'b0;
    if (g_e) begin
      q.push_back(int'(k)); m_last_enq = 1'b1;
      if (was_empty) begin
        chk("wr_we",   bus.mem_we, 1);
        chk("wr_addr", bus.mem_waddr, 1);
        chk("wr_data", bus.mem_wdata, k);
      end
    end else if (g_d) begin
      m_last_enq = 1'b0;
      mi = qmin_idx(); mv = q[mi]; q.delete(mi);
      chk("ov_early", bus.out_valid, 0);
      tick();
      chk("out_valid", bus.out_valid, 1);
      chk("out_key", bus.out_key, mv);
      dkey = bus.out_key;
    end
    wait_idle();
    chk_state();
  endtask

  initial begin
    int seq[5];
    seq = '{3, 5, 7, 8, 9};
    bus.enq_valid = 1'b0; bus.deq_valid = 1'b0; bus.enq_key = '0;
    m_last_enq = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // reset state
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full",  bus.full, 0);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_ov",    bus.out_valid, 0);
    chk("rst_okey",  bus.out_key, 0);
    chk("rst_we",    bus.mem_we, 0);
    chk("rst_addra", bus.mem_addr_a, 0);
    chk("rst_addrb", bus.mem_addr_b, 0);
    chk("rst_enqr",  bus.enq_ready, 1);
    chk("rst_deqr",  bus.deq_ready, 0);

    // single enqueue into empty heap
    xact(1, 0, 8'd5, ge, gd, dk);
    chk("t1_count", bus.count, 1);
    chk("t1_empty", bus.empty, 0);

    // ordered drain
    xact(1, 0, 8'd9, ge, gd, dk);
    xact(1, 0, 8'd7, ge, gd, dk);
    xact(1, 0, 8'd3, ge, gd, dk);
    xact(1, 0, 8'd8, ge, gd, dk);
    for (int i = 0; i < 5; i++) begin
      xact(0, 1, '0, ge, gd, dk);
      chk("t2_seq", dk, seq[i]);
    end
    chk("t2_empty", bus.empty, 1);
    xact(0, 1, '0, ge, gd, dk);
    chk("t2_deqr", obs_deq, 0);

    // fill to capacity
    for (int i = 0; i < DEPTH; i++) xact(1, 0, KEY_W'($urandom_range(0, 15)), ge, gd, dk);
    chk("t3_full", bus.full, 1);
    xact(1, 0, 8'd1, ge, gd, dk);
    chk("t3_enqr", obs_enq, 0);
    xact(0, 1, '0, ge, gd, dk);
    xact(1, 0, 8'd1, ge, gd, dk);
    chk("t3_reenq", bus.count, DEPTH);

    // arbitration with both requesting
    for (int i = 0; i < 3; i++) xact(0, 1, '0, ge, gd, dk);
    xact(1, 0, 8'd12, ge, gd, dk);
    for (int i = 0; i < 4; i++) begin
      xact(1, 1, KEY_W'($urandom_range(0, 15)), ge, gd, dk);
      chk("t4_deq_grant", obs_deq, (i % 2) == 0);
      chk("t4_enq_grant", obs_enq, (i % 2) == 1);
    end

    // reset during sift-down
    bus.deq_valid = 1'b1;
    @(negedge clk);
    chk("t5_deqr", bus.deq_ready, 1);
    tick();
    bus.deq_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t5_busy",  bus.busy, 0);
    chk("t5_count", bus.count, 0);
    chk("t5_we",    bus.mem_we, 0);
    chk("t5_ov",    bus.out_valid, 0);
    rst = 1'b0;
    q.delete();
    m_last_enq = 1'b0;

`ifdef PQ_PEEK_EN
    xact(1, 0, 8'd4, ge, gd, dk);
    xact(1, 0, 8'd2, ge, gd, dk);
    chk("t6_min_key",   bus.min_key, 2);
    chk("t6_min_valid", bus.min_valid, 1);
    xact(0, 1, '0, ge, gd, dk);
    xact(0, 1, '0, ge, gd, dk);
    chk("t6_min_clr", bus.min_valid, 0);
`endif

    // random traffic
    for (int i = 0; i < 300; i++)
      xact(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           KEY_W'($urandom_range(0, 15)), ge, gd, dk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
